// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access-width helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ERR, RESP} state_t;

  // Access size in bytes; only meaningful for legal funct3 codes.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Combinational load extension: picks the byte/half/word from the returned
// memory word and sign- or zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    case (funct3)
      LB:      result = {{24{word[7]}}, word[7:0]};
      LH:      result = {{16{word[15]}}, word[15:0]};
      LBU:     result = {24'b0, word[7:0]};
      LHU:     result = {16'b0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one op, checks it, pulses the memory read or
// write port once, and returns the load result or store acknowledgement.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_tag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_tag,
  output logic        resp_error,
  output logic [31:0] mem_read_addr,
  output logic        mem_read_req,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_req,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_write_type
);

  state_t      state, state_next;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [2:0]  wait_count;
  logic        wait_done;
  logic [31:0] ea;
  logic [32:0] ea_end;
  logic        legal, misaligned, out_of_range, reject;
  logic [31:0] store_value;
  logic [31:0] load_value;

  // Acceptance-time checks; the end address is kept 33 bits wide so an
  // access wrapping past 2^32 is still seen as out of range.
  always_comb begin
    ea     = req_base + req_offset;
    ea_end = {1'b0, ea} + 33'(access_bytes(req_funct3)) - 33'd1;
    if (req_is_store)
      legal = (req_funct3 == SB) || (req_funct3 == SH) || (req_funct3 == SW);
    else
      legal = req_funct3 inside {LB, LH, LW, LBU, LHU};
    case (access_bytes(req_funct3))
      3'd2:    misaligned = ea[0];
      3'd4:    misaligned = |ea[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = ea_end >= 33'(MEM_BYTES);
    reject       = !legal || misaligned || out_of_range;
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   store_value = {24'b0, req_store_data[7:0]};
      2'b01:   store_value = {16'b0, req_store_data[15:0]};
      default: store_value = req_store_data;
    endcase
  end

  load_extend u_extend (
    .funct3 (op_funct3),
    .word   (mem_read_data),
    .result (load_value)
  );

  assign wait_done = (wait_count == 3'(READ_LATENCY - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = reject ? ERR : ISSUE;
      ISSUE:   state_next = op_store ? RESP : WAIT;
      WAIT:    if (wait_done) state_next = RESP;
      ERR:     state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE);
    resp_valid    = (state == RESP);
    mem_read_req  = (state == ISSUE) && !op_store;
    mem_write_req = (state == ISSUE) && op_store;
  end

  // Memory addresses are only updated for accepted legal ops, so they hold
  // their last value between operations.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_store       <= 1'b0;
      op_funct3      <= '0;
      wait_count     <= '0;
      resp_data      <= '0;
      resp_tag       <= '0;
      resp_error     <= 1'b0;
      mem_read_addr  <= '0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      mem_write_type <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_store   <= req_is_store;
          op_funct3  <= req_funct3;
          wait_count <= '0;
          resp_data  <= '0;
          resp_tag   <= req_tag;
          resp_error <= reject;
          if (!reject) begin
            if (req_is_store) begin
              mem_write_addr <= ea;
              mem_write_data <= store_value;
              mem_write_type <= req_funct3;
            end else begin
              mem_read_addr <= ea;
            end
          end
        end
        WAIT: begin
          wait_count <= wait_count + 3'd1;
          if (wait_done) resp_data <= load_value;
        end
        default: ;
      endcase
    end
  end

endmodule
